// File: rtl/pe_array_seq_pkg.sv
// Shared constants, FSM state encoding and config legality check for the PE array sequencer.
package pe_array_seq_pkg;

  localparam int unsigned ACC_CNT_WD   = 12;
  localparam int unsigned TILE_CNT_WD  = 8;
  // Longest accumulation that cannot overflow an 18-bit signed accumulator (7 x 16384).
  localparam int unsigned MAX_ACC_LEN  = 7;
  localparam int unsigned PE_OUTPUT_WD = 18;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StAcc   = 3'd2,
    StDrain = 3'd3,
    StOut   = 3'd4
  } seq_state_e;

  function automatic logic cfg_illegal(input logic [ACC_CNT_WD-1:0]  acc_len,
                                       input logic [TILE_CNT_WD-1:0] tile_num);
    return (acc_len == '0) || (tile_num == '0) || (acc_len > ACC_CNT_WD'(MAX_ACC_LEN));
  endfunction

endpackage

// File: rtl/pe_seq_beat_cnt.sv
// Operand beat counter: latches the tile length at job start, counts reads, flags the last beat.
module pe_seq_beat_cnt
  import pe_array_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ACC_CNT_WD-1:0] len_i,
  input  logic                  clr_i,
  input  logic                  rd_i,
  output logic [ACC_CNT_WD-1:0] cnt_o,
  output logic                  last_o
);

  logic [ACC_CNT_WD-1:0] len_q, len_d;
  logic [ACC_CNT_WD-1:0] cnt_q, cnt_d;

  always_comb begin
    len_d = load_i ? len_i : len_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (rd_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/pe_array_seq.sv
// Tile sequencer for the pe2 array: clear, stream operand beats, drain, then hold results for
// writeback, repeated for each tile of a job.
module pe_array_seq
  import pe_array_seq_pkg::*;
#(
  parameter int unsigned ROW_NUM = 8,
  parameter int unsigned COL_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ACC_CNT_WD-1:0]  cfg_acc_len_i,
  input  logic [TILE_CNT_WD-1:0] cfg_tile_num_i,
  input  logic [ROW_NUM-1:0]     cfg_row_mask_i,
  input  logic [2*COL_NUM-1:0]   cfg_col_mask_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  input  logic                   src_vld_i,
  output logic                   src_rd_o,
  output logic [ACC_CNT_WD-1:0]  src_addr_o,
  output logic                   pe_clr_o,
  output logic                   pe_array_vld_o,
  output logic [ROW_NUM-1:0]     pe_row_vld_o,
  output logic [2*COL_NUM-1:0]   pe_col_vld_o,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output logic [TILE_CNT_WD-1:0] out_tile_idx_o
);

  seq_state_e             state_q, state_d;
  logic [TILE_CNT_WD-1:0] tile_num_q, tile_num_d;
  logic [TILE_CNT_WD-1:0] tile_q, tile_d;
  logic [ROW_NUM-1:0]     row_q, row_d;
  logic [2*COL_NUM-1:0]   col_q, col_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   arr_vld_q;
  logic                   start_ok;
  logic                   beat_last;
  logic                   cnt_clr;
  logic [ACC_CNT_WD-1:0]  beat_cnt;

  always_comb begin
    state_d    = state_q;
    tile_num_d = tile_num_q;
    tile_d     = tile_q;
    row_d      = row_q;
    col_d      = col_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    src_rd_o   = 1'b0;
    start_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_illegal(cfg_acc_len_i, cfg_tile_num_i)) begin
            err_d = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_d    = StClr;
            tile_num_d = cfg_tile_num_i;
            tile_d     = '0;
            row_d      = cfg_row_mask_i;
            col_d      = cfg_col_mask_i;
          end
        end
      end
      StClr:   state_d = StAcc;
      StAcc: begin
        src_rd_o = src_vld_i;
        if (src_vld_i && beat_last) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (out_rdy_i) begin
          if (tile_q == tile_num_q - 1'b1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = StClr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything else, including a same-cycle writeback handshake.
    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      src_rd_o = 1'b0;
      done_d   = 1'b0;
    end

    // Keep masks and tile index at zero whenever idle.
    if (state_d == StIdle) begin
      tile_d = '0;
      row_d  = '0;
      col_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tile_num_q <= '0;
      tile_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      arr_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_num_q <= tile_num_d;
      tile_q     <= tile_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      err_q      <= err_d;
      // Operand data arrives one cycle after the pop.
      arr_vld_q  <= src_rd_o;
    end
  end

  assign cnt_clr = (state_q == StClr) || (state_d == StIdle);

  pe_seq_beat_cnt u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_ok),
    .len_i  (cfg_acc_len_i),
    .clr_i  (cnt_clr),
    .rd_i   (src_rd_o),
    .cnt_o  (beat_cnt),
    .last_o (beat_last)
  );

  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign src_addr_o     = beat_cnt;
  assign pe_clr_o       = (state_q == StClr);
  assign pe_array_vld_o = arr_vld_q;
  assign pe_row_vld_o   = row_q;
  assign pe_col_vld_o   = col_q;
  assign out_vld_o      = (state_q == StOut);
  assign out_tile_idx_o = tile_q;

endmodule

// File: tb/tb_pe_array_seq.sv
// Self-checking bench for pe_array_seq: per-job expected timelines from a job-level model,
// directed scenarios plus randomized jobs.
module tb_pe_array_seq;

  localparam int unsigned ROW_NUM = 8;
  localparam int unsigned COL_NUM = 4;
  localparam int          H       = 256;
  localparam int          MAX_LEN = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [11:0] cfg_acc_len_i;
  logic [7:0]  cfg_tile_num_i;
  logic [7:0]  cfg_row_mask_i;
  logic [7:0]  cfg_col_mask_i;
  logic        busy_o, done_o, err_o;
  logic        src_vld_i, src_rd_o;
  logic [11:0] src_addr_o;
  logic        pe_clr_o, pe_array_vld_o;
  logic [7:0]  pe_row_vld_o, pe_col_vld_o;
  logic        out_vld_o, out_rdy_i;
  logic [7:0]  out_tile_idx_o;

  pe_array_seq #(
    .ROW_NUM (ROW_NUM),
    .COL_NUM (COL_NUM)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg_acc_len_i  (cfg_acc_len_i),
    .cfg_tile_num_i (cfg_tile_num_i),
    .cfg_row_mask_i (cfg_row_mask_i),
    .cfg_col_mask_i (cfg_col_mask_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .src_vld_i      (src_vld_i),
    .src_rd_o       (src_rd_o),
    .src_addr_o     (src_addr_o),
    .pe_clr_o       (pe_clr_o),
    .pe_array_vld_o (pe_array_vld_o),
    .pe_row_vld_o   (pe_row_vld_o),
    .pe_col_vld_o   (pe_col_vld_o),
    .out_vld_o      (out_vld_o),
    .out_rdy_i      (out_rdy_i),
    .out_tile_idx_o (out_tile_idx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Input patterns per cycle of a job (cycle 0 = start cycle).
  bit vld_pat[H];
  bit rdy_pat[H];
  // Expected per-cycle behaviour of the current job.
  bit e_busy[H], e_clr[H], e_rd[H], e_pvld[H], e_ovld[H], e_done[H], e_err[H];
  int e_addr[H], e_tile[H];
  int end_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic fill_const(input bit v, input bit r);
    for (int i = 0; i < H; i++) begin
      vld_pat[i] = v;
      rdy_pat[i] = r;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < H; i++) begin
      vld_pat[i] = (i >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rdy_pat[i] = (i >= 200) ? 1'b1 : ($urandom_range(0, 1) != 0);
    end
  endtask

  // Walks the job tile by tile: one clear cycle, len beats taken on cycles with an available
  // operand, one drain cycle, then results held until writeback takes them.
  task automatic model_job(input int len, input int tiles, input int abort_at);
    int  t;
    int  beats;
    bit  stop;
    bit  taken;
    for (int i = 0; i < H; i++) begin
      e_busy[i] = 0; e_clr[i] = 0; e_rd[i] = 0; e_pvld[i] = 0;
      e_ovld[i] = 0; e_done[i] = 0; e_err[i] = 0; e_addr[i] = 0; e_tile[i] = 0;
    end
    if (len == 0 || tiles == 0 || len > MAX_LEN) begin
      e_err[1] = 1;
      end_t = 3;
      return;
    end
    t    = 1;
    stop = 0;
    for (int k = 0; k < tiles && !stop; k++) begin
      e_busy[t] = 1; e_tile[t] = k; e_clr[t] = 1;
      stop = (t == abort_at);
      t++;
      beats = 0;
      while (!stop && beats < len && t < H - 2) begin
        e_busy[t] = 1; e_tile[t] = k;
        if (t == abort_at) stop = 1;
        else if (vld_pat[t]) begin
          e_rd[t] = 1; e_addr[t] = beats; e_pvld[t+1] = 1;
          beats++;
        end
        t++;
      end
      if (!stop) begin
        e_busy[t] = 1; e_tile[t] = k;
        stop = (t == abort_at);
        t++;
      end
      taken = 0;
      while (!stop && !taken && t < H - 2) begin
        e_busy[t] = 1; e_tile[t] = k; e_ovld[t] = 1;
        if (t == abort_at) stop = 1;
        else if (rdy_pat[t]) begin
          taken = 1;
          if (k == tiles - 1) e_done[t+1] = 1;
        end
        t++;
      end
    end
    end_t = t + 1;
  endtask

  task automatic run_job(input int len, input int tiles, input logic [7:0] rowm,
                         input logic [7:0] colm, input int abort_at);
    model_job(len, tiles, abort_at);
    for (int t = 0; t <= end_t; t++) begin
      @(posedge clk);
      #2;
      start_i   = (t == 0) || (e_busy[t] && ($urandom_range(0, 7) == 0));
      abort_i   = (t == abort_at);
      src_vld_i = vld_pat[t];
      out_rdy_i = rdy_pat[t];
      if (t == 0) begin
        cfg_acc_len_i  = 12'(len);
        cfg_tile_num_i = 8'(tiles);
        cfg_row_mask_i = rowm;
        cfg_col_mask_i = colm;
      end else begin
        // Garbage config after the start cycle must not disturb the latched job.
        cfg_acc_len_i  = 12'($urandom_range(0, 15));
        cfg_tile_num_i = 8'($urandom_range(0, 5));
        cfg_row_mask_i = 8'($urandom);
        cfg_col_mask_i = 8'($urandom);
      end
      #2;
      check("busy", 32'(busy_o), 32'(e_busy[t]));
      check("pe_clr", 32'(pe_clr_o), 32'(e_clr[t]));
      check("src_rd", 32'(src_rd_o), 32'(e_rd[t]));
      if (e_rd[t]) check("src_addr", 32'(src_addr_o), 32'(e_addr[t]));
      check("pe_array_vld", 32'(pe_array_vld_o), 32'(e_pvld[t]));
      check("out_vld", 32'(out_vld_o), 32'(e_ovld[t]));
      check("tile_idx", 32'(out_tile_idx_o), 32'(e_tile[t]));
      check("done", 32'(done_o), 32'(e_done[t]));
      check("err", 32'(err_o), 32'(e_err[t]));
      check("row_vld", 32'(pe_row_vld_o), 32'(e_busy[t] ? rowm : 8'h00));
      check("col_vld", 32'(pe_col_vld_o), 32'(e_busy[t] ? colm : 8'h00));
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_src_rd"}, 32'(src_rd_o), 32'd0);
    check({tag, "_src_addr"}, 32'(src_addr_o), 32'd0);
    check({tag, "_pe_clr"}, 32'(pe_clr_o), 32'd0);
    check({tag, "_pe_vld"}, 32'(pe_array_vld_o), 32'd0);
    check({tag, "_row"}, 32'(pe_row_vld_o), 32'd0);
    check({tag, "_col"}, 32'(pe_col_vld_o), 32'd0);
    check({tag, "_out_vld"}, 32'(out_vld_o), 32'd0);
    check({tag, "_tile"}, 32'(out_tile_idx_o), 32'd0);
  endtask

  // len=1, tiles=1, writeback never ready: reaches the hold phase on cycle 4, then reset hits.
  task automatic reset_mid_out();
    @(posedge clk);
    #2;
    start_i = 1'b1; abort_i = 1'b0; src_vld_i = 1'b1; out_rdy_i = 1'b0;
    cfg_acc_len_i = 12'd1; cfg_tile_num_i = 8'd1;
    cfg_row_mask_i = 8'hA5; cfg_col_mask_i = 8'h3C;
    repeat (4) begin
      @(posedge clk);
      #2;
      start_i = 1'b0;
    end
    #2;
    check("rst_pre_out_vld", 32'(out_vld_o), 32'd1);
    check("rst_pre_row", 32'(pe_row_vld_o), 32'hA5);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)",
             n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit   pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int   len, tiles, ab;
    logic [7:0] rowm, colm;

    rst = 1'b1;
    start_i = 1'b0; abort_i = 1'b0; src_vld_i = 1'b0; out_rdy_i = 1'b0;
    cfg_acc_len_i = '0; cfg_tile_num_i = '0; cfg_row_mask_i = '0; cfg_col_mask_i = '0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic single tile, everything always ready.
    fill_const(1, 1);
    run_job(3, 1, 8'hFF, 8'hFF, -1);

    // Operand stalls.
    fill_const(0, 1);
    for (int i = 0; i < 7; i++) vld_pat[2+i] = pat[i];
    run_job(4, 1, 8'hFF, 8'hFF, -1);

    // Writeback backpressure on tile 1 (its hold phase starts on cycle 10).
    fill_const(1, 1);
    for (int i = 10; i < 15; i++) rdy_pat[i] = 0;
    run_job(2, 3, 8'h0F, 8'hF0, -1);

    // Illegal configurations.
    fill_const(1, 1);
    run_job(0, 2, 8'hFF, 8'hFF, -1);
    run_job(3, 0, 8'hFF, 8'hFF, -1);
    run_job(8, 1, 8'hFF, 8'hFF, -1);
    run_job(7, 1, 8'h81, 8'h18, -1);

    // Abort on beat 2 of 5, then a clean restart.
    fill_const(1, 1);
    run_job(5, 1, 8'hFF, 8'hFF, 4);
    run_job(5, 1, 8'h55, 8'hAA, -1);

    // Abort racing the writeback handshake of the last tile.
    fill_const(1, 1);
    run_job(1, 1, 8'hFF, 8'hFF, 4);

    reset_mid_out();
    fill_const(1, 1);
    run_job(3, 2, 8'hC3, 8'h3C, -1);

    for (int j = 0; j < 40; j++) begin
      len   = $urandom_range(0, 8);
      tiles = $urandom_range(0, 3);
      rowm  = 8'($urandom);
      colm  = 8'($urandom);
      ab    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : -1;
      fill_random();
      run_job(len, tiles, rowm, colm, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
